// File: rtl/wand_arbiter.sv
// Bit-serial wired-AND arbiter: channels shift their identifiers MSB first onto a
// shared open-drain-style bus; a channel that sends 1 but reads 0 drops out.

module wand_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic         req,
  input  logic         bus_bit,
  input  logic [W-1:0] id,
  output logic         drive,
  output logic         act,
  output logic         act_nxt
);
  logic [W-1:0] sreg;

  // A dropped channel releases the bus (drives recessive 1).
  assign drive   = act ? sreg[W-1] : 1'b1;
  assign act_nxt = act & ~(sreg[W-1] & ~bus_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      act  <= 1'b0;
    end else if (load) begin
      sreg <= id;
      act  <= req;
    end else if (shift) begin
      sreg <= {sreg[W-2:0], 1'b0};
      act  <= act_nxt;
    end
  end
endmodule

module wand_arbiter #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*W-1:0] id_flat,
  output logic              bus_bit,
  output logic              busy,
  output logic              done,
  output logic [N_CH-1:0]   grant,
  output logic [W-1:0]      win_id,
  output logic              collision,
  output logic [N_CH-1:0]   active
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, ARB, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [W-2:0]    win_sh;
  logic [W-1:0]    win_nxt;
  logic [N_CH-1:0] drive, act_nxt, grant_nxt;
  logic            accept, last;

  assign accept    = (state == IDLE) && start;
  assign last      = (bit_cnt == CW'(W-1));
  assign bus_bit   = (state == ARB) ? &drive : 1'b1;
  assign busy      = (state == ARB);
  assign done      = (state == DONE);
  assign win_nxt   = {win_sh, bus_bit};
  // Isolate lowest set bit of the surviving set.
  assign grant_nxt = act_nxt & (~act_nxt + N_CH'(1));

  wand_lane #(.W(W)) u_lane [N_CH-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .shift   (busy),
    .req     (req),
    .bus_bit (bus_bit),
    .id      (id_flat),
    .drive   (drive),
    .act     (active),
    .act_nxt (act_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      win_sh    <= '0;
      grant     <= '0;
      win_id    <= '0;
      collision <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bit_cnt   <= '0;
          win_sh    <= '0;
          grant     <= '0;
          win_id    <= '0;
          collision <= 1'b0;
          state     <= (|req) ? ARB : DONE;
        end
        ARB: begin
          bit_cnt <= bit_cnt + CW'(1);
          win_sh  <= win_nxt[W-2:0];
          if (last) begin
            state     <= DONE;
            grant     <= grant_nxt;
            win_id    <= win_nxt;
            collision <= |(act_nxt & (act_nxt - N_CH'(1)));
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wand_arbiter.sv
// Directed bench for wand_arbiter (N_CH=4, W=8) with a min-id reference model
// checked every cycle plus literal expectations for each scenario.

module tb_wand_arbiter;
  logic        clk = 0;
  logic        rst_n, start;
  logic [3:0]  req;
  logic [31:0] id_flat;
  logic        bus_bit, busy, done, collision;
  logic [3:0]  grant, active;
  logic [7:0]  win_id;

  int checks = 0;
  int errors = 0;

  wand_arbiter #(.N_CH(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req(req), .id_flat(id_flat),
    .bus_bit(bus_bit), .busy(busy), .done(done), .grant(grant),
    .win_id(win_id), .collision(collision), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference model: phase 0 idle, 1 arbitrating, 2 done.
  int         m_ph = 0, m_cnt = 0;
  logic [3:0] m_grant = 0, m_act = 0, e_set = 0, e_grant = 0, m_req = 0;
  logic [7:0] m_win = 0, e_min = 8'hFF;
  logic       m_col = 0, e_col = 0;
  logic [31:0] m_ids = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_cnt = 0; m_grant = 0; m_win = 0; m_col = 0; m_act = 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_grant = 0; m_win = 0; m_col = 0;
          if (req == 0) begin
            m_ph = 2; m_act = 0;
          end else begin
            m_req = req; m_ids = id_flat; e_min = 8'hFF;
            for (int i = 0; i < 4; i++)
              if (req[i] && m_ids[i*8 +: 8] < e_min) e_min = m_ids[i*8 +: 8];
            e_set = 0;
            for (int i = 0; i < 4; i++)
              if (req[i] && m_ids[i*8 +: 8] == e_min) e_set[i] = 1'b1;
            e_grant = 0;
            for (int i = 3; i >= 0; i--)
              if (e_set[i]) begin e_grant = 0; e_grant[i] = 1'b1; end
            e_col = ($countones(e_set) > 1);
            m_act = req; m_cnt = 0; m_ph = 1;
          end
        end
        1: begin
          m_cnt++;
          // Survivors are requesters whose id prefix matches the minimum so far.
          m_act = 0;
          for (int i = 0; i < 4; i++)
            if (m_req[i] && ((int'(m_ids[i*8 +: 8]) >> (8 - m_cnt)) == (int'(e_min) >> (8 - m_cnt))))
              m_act[i] = 1'b1;
          if (m_cnt == 8) begin
            m_ph = 2; m_grant = e_grant; m_win = e_min; m_col = e_col; m_act = e_set;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic exp_bus;
    exp_bus = (m_ph == 1) ? e_min[7 - m_cnt] : 1'b1;
    chk("busy", busy, m_ph == 1);
    chk("done", done, m_ph == 2);
    chk("bus_bit", bus_bit, exp_bus);
    chk("grant", grant, m_grant);
    chk("win_id", win_id, m_win);
    chk("collision", collision, m_col);
    chk("active", active, m_act);
  end

  task automatic run_round(input logic [3:0] r, input logic [31:0] ids, input int pulse,
                           input int mut, output int lat, output int nbusy, output logic [7:0] bseq);
    start = 1; req = r; id_flat = ids;
    lat = 0; nbusy = 0; bseq = 0;
    do begin
      @(negedge clk); lat++;
      start = (lat == pulse);
      if (lat == mut) begin id_flat = ~id_flat; req = ~req; end
      if (busy) begin nbusy++; bseq = {bseq[6:0], bus_bit}; end
    end while (!done && lat < 40);
    start = 0;
    chk("done_seen", done, 1'b1);
  endtask

  task automatic quiet(input int n, output int ndone, output int nbusy);
    ndone = 0; nbusy = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
  endtask

  initial begin
    int lat, nb, nd, nb2;
    logic [7:0] bs;
    rst_n = 1; start = 0; req = 0; id_flat = 0;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_bus", bus_bit, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 4'b0);
    rst_n = 1;
    @(negedge clk);

    // Four contenders, 3C wins.
    run_round(4'b1111, 32'hFF3F3C5A, 0, 0, lat, nb, bs);
    chk("t1_lat", lat, 9);
    chk("t1_busy_cycles", nb, 8);
    chk("t1_bus_seq", bs, 8'b00111100);
    chk("t1_grant", grant, 4'b0010);
    chk("t1_win", win_id, 8'h3C);
    chk("t1_col", collision, 1'b0);
    @(negedge clk);

    // Tie between ch0 and ch2; ch1 holds 00 but is not requesting.
    run_round(4'b0101, 32'h00100010, 0, 0, lat, nb, bs);
    chk("t2_grant", grant, 4'b0001);
    chk("t2_win", win_id, 8'h10);
    chk("t2_col", collision, 1'b1);
    chk("t2_active", active, 4'b0101);
    @(negedge clk);

    // Empty round.
    run_round(4'b0000, 32'h12345678, 0, 0, lat, nb, bs);
    chk("t3_lat", lat, 1);
    chk("t3_busy_cycles", nb, 0);
    chk("t3_grant", grant, 4'b0);
    chk("t3_win", win_id, 8'h0);
    @(negedge clk);

    // Single requester with id 00; extra start mid-round must be ignored.
    run_round(4'b1000, 32'h00FFFFFF, 4, 0, lat, nb, bs);
    chk("t4_lat", lat, 9);
    chk("t4_grant", grant, 4'b1000);
    chk("t4_win", win_id, 8'h00);
    quiet(12, nd, nb2);
    chk("t4_no_second_done", nd, 0);
    chk("t4_no_second_busy", nb2, 0);
    chk("t4_grant_held", grant, 4'b1000);

    // Reset during bit 4 of a round.
    start = 1; req = 4'b1111; id_flat = 32'hFF3F3C5A;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_bus", bus_bit, 1'b1);
    chk("t5_grant", grant, 4'b0);
    chk("t5_win", win_id, 8'h0);
    chk("t5_col", collision, 1'b0);
    chk("t5_active", active, 4'b0);
    @(negedge clk);
    rst_n = 1;
    quiet(12, nd, nb2);
    chk("t5_no_done", nd, 0);
    run_round(4'b1111, 32'hFF3F3C5A, 0, 0, lat, nb, bs);
    chk("t5_lat", lat, 9);
    chk("t5_win_after", win_id, 8'h3C);
    chk("t5_grant_after", grant, 4'b0010);
    @(negedge clk);

    // Inputs scrambled mid-round must not affect the result.
    run_round(4'b1111, 32'hFF3F3C5A, 0, 3, lat, nb, bs);
    chk("t6_bus_seq", bs, 8'b00111100);
    chk("t6_grant", grant, 4'b0010);
    chk("t6_win", win_id, 8'h3C);
    chk("t6_col", collision, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wand_arbiter.md
WAND_ARBITER -- requirements
Module: wand_arbiter

Parameters
REQ-001 SHALL have N_CH, default 4, number of contending channels (2..16).
REQ-002 SHALL have W, default 8, identifier width in bits (2..32).

Interface
REQ-003 SHALL have clk  input  1  rising-edge clock.
REQ-004 SHALL have rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have start  input  1  begin an arbitration round; sampled only in IDLE.
REQ-006 SHALL have req  input  N_CH  channels participating; sampled with start.
REQ-007 SHALL have id_flat  input  N_CH*W  channel i identifier at bits [i*W+W-1 : i*W]; sampled with start.
REQ-008 SHALL have bus_bit  output  1  wired-AND bus value for the current bit.
REQ-009 SHALL have busy  output  1  high while in ARB.
REQ-010 SHALL have done  output  1  one-cycle pulse at round completion.
REQ-011 SHALL have grant  output  N_CH  one-hot winner, or all-zero if there was no requester.
REQ-012 SHALL have win_id  output  W  winning identifier.
REQ-013 SHALL have collision  output  1  more than one channel survived all W bits.
REQ-014 SHALL have active  output  N_CH  channels still contending.

Function
REQ-015 SHALL implement FSM states IDLE, ARB and DONE.
REQ-016 SHALL, on start in IDLE with req!=0, load one W-bit shift register per channel from id_flat, set active=req, clear bit_cnt, clear grant/win_id/collision, and go to ARB.
REQ-017 SHALL, on start in IDLE with req==0, go to DONE with grant=0, win_id=0 and collision=0.
REQ-018 SHALL drive bus_bit in ARB combinationally as the AND over all i of (active[i] ? sreg[i][W-1] : 1), MSB first; 0 is dominant.
REQ-019 SHALL drive bus_bit to 1 (released) in IDLE and DONE.
REQ-020 SHALL, at each ARB clock edge, clear active[i] for every channel with active[i]=1, sreg[i][W-1]=1 and bus_bit=0; all other active bits hold.
REQ-021 SHALL, at each ARB clock edge, shift every sreg left by 1 and increment bit_cnt.
REQ-022 SHALL stay in ARB for exactly W cycles and go to DONE after the edge where bit_cnt=W-1.
REQ-023 SHALL, on entering DONE, set grant to the lowest-index set bit of the final active value.
REQ-024 SHALL, on entering DONE, set win_id to the W bus_bit values captured MSB first.
REQ-025 SHALL, on entering DONE, set collision=1 iff popcount(final active)>1.
REQ-026 SHALL spend exactly 1 cycle in DONE with done=1, then return to IDLE.
REQ-027 SHALL hold grant, win_id and collision until the next accepted start or reset.
REQ-028 SHALL, for latency, with start sampled at edge k, hold busy=1 for cycles k+1..k+W and done=1 in cycle k+W+1; a req==0 round has done in cycle k+1.
REQ-029 SHALL ignore start in ARB or DONE; there is no queuing.
REQ-030 SHALL sample req/id_flat only at an accepted start; later changes have no effect on the round.
REQ-031 SHALL award the numerically lowest identifier among the requesters.

Reset
REQ-032 SHALL, when rst_n=0 and asynchronously in any state including mid-ARB, force IDLE, bus_bit=1, busy=0, done=0, grant=0, win_id=0, collision=0, active=0, bit_cnt=0 and sreg=0.
REQ-033 SHALL resume normal operation at the first clk edge after rst_n deasserts; an interrupted round is abandoned and produces no done.

Verification (N_CH=4, W=8)
REQ-034 SHALL verify: req=1111, ids ch0..3 = 5A,3C,3F,FF, start -> bus_bit sequence 0,0,1,1,1,1,0,0; done 9 cycles after start; grant=0010, win_id=3C, collision=0.
REQ-035 SHALL verify: req=0101, ch0=10, ch2=10 -> grant=0001, win_id=10, collision=1, active=0101 at DONE.
REQ-036 SHALL verify: req=0000, start -> done next cycle, grant=0000, busy never high.
REQ-037 SHALL verify: req=1000, ch3=00 -> grant=1000, win_id=00; a start pulse at bit 3 is ignored and no second round follows.
REQ-038 SHALL verify: rst_n low at bit 4 of the REQ-034 round -> outputs at reset values immediately, no done; a fresh start after release completes normally.
REQ-039 SHALL verify: id_flat changed during ARB -> result identical to REQ-034.
